// File: rtl/key_pkg.sv
// Shared types and the round-robin grant helper for the front-panel key controller.
package key_pkg;

  localparam int unsigned MAX_KEYS  = 8;
  localparam int unsigned MAX_IDX_W = 3;

  typedef enum logic [0:0] {
    KEY_IDLE,
    KEY_OFFER
  } key_state_e;

  typedef struct packed {
    logic valid;
    logic polarity;
  } key_slot_t;

  // First set bit of req at or after ptr, wrapping mod nkeys; caller guarantees req != 0.
  function automatic logic [MAX_IDX_W-1:0] rr_next_grant(
    input logic [MAX_KEYS-1:0]  req,
    input logic [MAX_IDX_W-1:0] ptr,
    input int unsigned          nkeys
  );
    logic [MAX_IDX_W-1:0] grant;
    logic [MAX_IDX_W-1:0] idx;
    grant = ptr;
    for (int i = int'(MAX_KEYS) - 1; i >= 0; i--) begin
      if (i < int'(nkeys)) begin
        idx = MAX_IDX_W'((int'(ptr) + i) % int'(nkeys));
        if (req[idx]) grant = idx;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/key_filter.sv
// One key: 2-flop synchroniser plus stability counter that qualifies level changes.
module key_filter #(
  parameter int unsigned SAMPLE_TIME = 20'hF_FFFF
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_level
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_TIME + 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // Level flips on the SAMPLE_TIME-th consecutive cycle of disagreement.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync      <= '0;
      cnt       <= '0;
      key_level <= 1'b0;
    end else begin
      sync <= {sync[0], key_raw};
      if (sync[1] == key_level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(SAMPLE_TIME - 1)) begin
        key_level <= sync[1];
        cnt       <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// Filters NKEYS buttons and serialises their level changes round-robin onto one event port.
// Define KEY_RELEASE_EV_EN to also emit release events (ev_press=0).
module key_event_ctrl
  import key_pkg::*;
#(
  parameter  int unsigned NKEYS       = 4,
  parameter  int unsigned SAMPLE_TIME = 20'hF_FFFF,
  localparam int unsigned IDX_W       = $clog2(NKEYS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NKEYS-1:0] key_in,
  output logic [NKEYS-1:0] key_level,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [IDX_W-1:0] ev_key,
  output logic             ev_press,
  output logic             overrun
);

  key_state_e       state;
  key_slot_t        slot [NKEYS];
  logic [NKEYS-1:0] level_prev;
  logic [IDX_W-1:0] rr_ptr;

  logic [NKEYS-1:0] slot_valid_c;
  logic [NKEYS-1:0] load_c;
  logic [IDX_W-1:0] grant_idx_c;
  logic             grant_c;

  for (genvar k = 0; k < NKEYS; k++) begin : g_key
    key_filter #(.SAMPLE_TIME(SAMPLE_TIME)) u_filter (
      .clk       (clk),
      .reset     (reset),
      .key_raw   (key_in[k]),
      .key_level (key_level[k])
    );
  end

  always_comb begin
    for (int k = 0; k < int'(NKEYS); k++) slot_valid_c[k] = slot[k].valid;
`ifdef KEY_RELEASE_EV_EN
    load_c = key_level ^ level_prev;
`else
    load_c = (key_level ^ level_prev) & key_level;
`endif
    grant_c     = (state == KEY_IDLE) && (|slot_valid_c);
    grant_idx_c = IDX_W'(rr_next_grant(MAX_KEYS'(slot_valid_c), MAX_IDX_W'(rr_ptr), NKEYS));
  end

`ifndef KEY_RELEASE_EV_EN
  assign ev_press = 1'b1;
`endif

  // Slot bookkeeping, arbitration pointer and the IDLE/OFFER event port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= KEY_IDLE;
      level_prev <= '0;
      rr_ptr     <= '0;
      ev_valid   <= 1'b0;
      ev_key     <= '0;
`ifdef KEY_RELEASE_EV_EN
      ev_press   <= 1'b0;
`endif
      overrun    <= 1'b0;
      for (int k = 0; k < int'(NKEYS); k++) slot[k] <= '0;
    end else begin
      level_prev <= key_level;
      // A slot granted this cycle can absorb a new edge without loss.
      for (int k = 0; k < int'(NKEYS); k++) begin
        if (grant_c && (grant_idx_c == IDX_W'(k))) begin
          slot[k] <= load_c[k] ? key_slot_t'{valid: 1'b1, polarity: key_level[k]} : '0;
        end else if (load_c[k]) begin
          if (slot[k].valid) overrun <= 1'b1;
          else               slot[k] <= key_slot_t'{valid: 1'b1, polarity: key_level[k]};
        end
      end
      case (state)
        KEY_IDLE: begin
          if (grant_c) begin
            ev_valid <= 1'b1;
            ev_key   <= grant_idx_c;
`ifdef KEY_RELEASE_EV_EN
            ev_press <= slot[grant_idx_c].polarity;
`endif
            rr_ptr   <= (grant_idx_c == IDX_W'(NKEYS - 1)) ? '0 : grant_idx_c + IDX_W'(1);
            state    <= KEY_OFFER;
          end
        end
        KEY_OFFER: begin
          if (ev_ready) begin
            ev_valid <= 1'b0;
            state    <= KEY_IDLE;
          end
        end
        default: state <= KEY_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed plus randomized bench for key_event_ctrl, checked against a per-key event queue model.
module tb_key_event_ctrl;

  localparam int unsigned NK = 4;
  localparam int unsigned ST = 4;
  localparam int unsigned IW = 2;
`ifdef KEY_RELEASE_EV_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ev_ready = 1'b1;
  logic [NK-1:0] key_in = '1;
  logic [NK-1:0] key_level;
  logic          ev_valid, ev_press, overrun;
  logic [IW-1:0] ev_key;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  key_event_ctrl #(.NKEYS(NK), .SAMPLE_TIME(ST)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_in    (key_in),
    .key_level (key_level),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_key    (ev_key),
    .ev_press  (ev_press),
    .overrun   (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; key_in = '0; ev_ready = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  // Wait (bounded) for an offered event, check it, then let one edge pass.
  task automatic wait_ev(input string tag, input int key, input bit press);
    int n = 0;
    while (!ev_valid && n < 80) begin step(); n++; end
    chk({tag, "_valid"}, 32'(ev_valid), 1);
    chk({tag, "_key"},   32'(ev_key),   32'(key));
    chk({tag, "_press"}, 32'(ev_press), 32'(press));
    step();
  endtask

  // Reference: a level is accepted after ST consecutive disagreeing samples of the input
  // seen two cycles late; every accepted change that produces an event is queued per key.
  bit [NK-1:0]   m_level = '0, h0 = '0, h1 = '0;
  int            mism [NK];
  bit            exp_q [NK][$];
  bit            prev_hs = 1'b0, prev_hold = 1'b0;
  logic [IW-1:0] prev_key;
  logic          prev_press;

  always @(negedge clk) begin
    bit e;
    chk("key_level", 32'(key_level), 32'(m_level));
    if (prev_hs) chk("ev_gap", 32'(ev_valid), 0);
    if (prev_hold) begin
      chk("hold_valid", 32'(ev_valid), 1);
      chk("hold_key",   32'(ev_key),   32'(prev_key));
      chk("hold_press", 32'(ev_press), 32'(prev_press));
    end
    prev_hs = 1'b0;
    prev_hold = 1'b0;
    if (!reset && ev_valid) begin
      if (ev_ready) begin
        prev_hs = 1'b1;
        chk("ev_queued", 32'(exp_q[ev_key].size() > 0), 1);
        if (exp_q[ev_key].size() > 0) begin
          e = exp_q[ev_key].pop_front();
          chk("ev_polarity", 32'(ev_press), 32'(e));
        end
      end else begin
        prev_hold = 1'b1; prev_key = ev_key; prev_press = ev_press;
      end
    end
    if (reset) begin
      m_level = '0; h0 = '0; h1 = '0;
      for (int k = 0; k < NK; k++) begin mism[k] = 0; exp_q[k].delete(); end
    end else begin
      for (int k = 0; k < NK; k++) begin
        if (h1[k] != m_level[k]) begin
          mism[k]++;
          if (mism[k] == ST) begin
            m_level[k] = h1[k];
            mism[k] = 0;
            if (h1[k] || REL) exp_q[k].push_back(h1[k]);
          end
        end else mism[k] = 0;
      end
      h1 = h0;
      h0 = key_in;
    end
  end

  initial begin
    int hold [NK];
    int low_run;
    int total;

    // Reset with all keys held, then the four presses in index order.
    step(3);
    chk("rst_level",   32'(key_level), 0);
    chk("rst_valid",   32'(ev_valid),  0);
    chk("rst_key",     32'(ev_key),    0);
`ifdef KEY_RELEASE_EV_EN
    chk("rst_press",   32'(ev_press),  0);
`endif
    chk("rst_overrun", 32'(overrun),   0);
    reset = 1'b0;
    for (int i = 0; i < NK; i++) wait_ev("rst_order", i, 1'b1);
    key_in = '0;
    step(40);

    // Single press: exact latency.
    do_reset(); step(2);
    key_in[2] = 1'b1;
    step(5); chk("sp_level_early", 32'(key_level[2]), 0);
    step();  chk("sp_level",       32'(key_level[2]), 1);
    step();  chk("sp_valid_early", 32'(ev_valid), 0);
    step();  chk("sp_valid", 32'(ev_valid), 1);
    chk("sp_key", 32'(ev_key), 2);
    chk("sp_press", 32'(ev_press), 1);
    step();  chk("sp_valid_drop", 32'(ev_valid), 0);
    key_in = '0;
    step(30);

    // Glitch of 3 cycles.
    do_reset(); step(2);
    key_in[1] = 1'b1; step(3); key_in[1] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("gl_level", 32'(key_level), 0);
      chk("gl_valid", 32'(ev_valid), 0);
      step();
    end
    chk("gl_overrun", 32'(overrun), 0);

    // Round robin between keys 0 and 3.
    do_reset(); step(2);
    key_in = 4'b1001;
    wait_ev("rr_a0", 0, 1'b1);
    wait_ev("rr_a3", 3, 1'b1);
    key_in = '0;
`ifdef KEY_RELEASE_EV_EN
    wait_ev("rr_r0", 0, 1'b0);
    wait_ev("rr_r3", 3, 1'b0);
`else
    step(20);
`endif
    step(5);
    key_in = 4'b1001;
    wait_ev("rr_b0", 0, 1'b1);
    wait_ev("rr_b3", 3, 1'b1);
    key_in = '0;
    step(30);

`ifdef KEY_RELEASE_EV_EN
    // Backpressure: release fills the slot, second press overruns.
    do_reset(); ev_ready = 1'b0; step(2);
    key_in[0] = 1'b1;
    wait_ev("bp_first", 0, 1'b1);
    key_in[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("bp_hold_valid", 32'(ev_valid), 1);
      chk("bp_hold_key",   32'(ev_key),   0);
      chk("bp_hold_press", 32'(ev_press), 1);
      step();
    end
    chk("bp_no_overrun", 32'(overrun), 0);
    key_in[0] = 1'b1;
    step(12);
    chk("bp_overrun", 32'(overrun), 1);
    ev_ready = 1'b1;
    wait_ev("bp_press", 0, 1'b1);
    wait_ev("bp_release", 0, 1'b0);
    step(10);
    chk("bp_dropped", 32'(ev_valid), 0);
    chk("bp_sticky", 32'(overrun), 1);
`else
    // Release edges produce no event.
    do_reset(); step(2);
    key_in[1] = 1'b1;
    wait_ev("off_press", 1, 1'b1);
    step(10);
    key_in[1] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      chk("off_no_ev", 32'(ev_valid), 0);
      step();
    end
    chk("off_level", 32'(key_level[1]), 0);
`endif

    // Reset while an event is being offered discards it.
    do_reset(); ev_ready = 1'b0; step(2);
    key_in[2] = 1'b1;
    wait_ev("mr_offer", 2, 1'b1);
    reset = 1'b1; key_in = '0;
    step();
    chk("mr_valid", 32'(ev_valid), 0);
    chk("mr_overrun", 32'(overrun), 0);
    reset = 1'b0; ev_ready = 1'b1;
    step(20);
    chk("mr_no_ev", 32'(ev_valid), 0);

    // Random toggles (glitches and long holds) with bursty ready.
    do_reset(); step(2);
    for (int k = 0; k < NK; k++) hold[k] = $urandom_range(50, 1);
    low_run = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < NK; k++) begin
        hold[k]--;
        if (hold[k] <= 0) begin
          key_in[k] = ~key_in[k];
          hold[k] = ($urandom_range(3, 0) == 0) ? $urandom_range(3, 1) : $urandom_range(50, 30);
        end
      end
      ev_ready = (low_run >= 2) ? 1'b1 : 1'(($urandom_range(1, 0)));
      low_run = ev_ready ? 0 : low_run + 1;
      step();
    end
    ev_ready = 1'b1;
    step(60);
    key_in = '0;
    step(100);
    chk("rnd_overrun", 32'(overrun), 0);
    total = 0;
    for (int k = 0; k < NK; k++) total += exp_q[k].size();
    chk("rnd_drained", 32'(total), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/key_event_ctrl.md
# key_event_ctrl

Front-panel key controller for the board-level CPU harness. It filters NKEYS raw push-button inputs (synchronise plus stability count) and turns each accepted level change into a single event. Contending events are scheduled round-robin onto one valid/ready event port, which feeds the CPU step/run/display control logic. It replaces the per-button free-running debounce instances with one sequenced, lossless-or-flagged event stream.

## Interface
- NKEYS, 4: number of keys (2..8).
- SAMPLE_TIME, 20'hF_FFFF: consecutive stable cycles needed to accept a level change (≥2).
- IDX_W, $clog2(NKEYS): key index width (derived, not overridden).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- key_in  in  NKEYS  raw asynchronous button levels; 1 = pressed.
- key_level  out  NKEYS  filtered levels.
- ev_valid  out  1  event available.
- ev_ready  in  1  consumer accepts event when ev_valid && ev_ready.
- ev_key  out  IDX_W  index of the key that caused the event.
- ev_press  out  1  1 = press (0→1), 0 = release.
- overrun  out  1  sticky; an edge was dropped. Cleared only by reset.

## Operation
- Per key filter: 2-flop synchroniser. A counter counts consecutive cycles where the synced value ≠ key_level. The counter clears when the values are equal. When the count reaches SAMPLE_TIME, key_level takes the synced value and the counter clears. The counter never wraps.
- Edge detect: when key_level changes, the key's pending slot loads {valid=1, polarity=new level}.
- Slot full, no grant this cycle: a new edge is dropped, overrun←1, and the old slot is kept.
- Slot being granted in the same cycle: the slot reloads with the new edge and overrun is not set.
- Arbiter: round-robin over valid slots. Search starts at rr_ptr. On a grant, rr_ptr←granted+1, wrapping mod NKEYS.
- FSM, states IDLE and OFFER.
  - IDLE: if any slot is valid, grant one. Copy its index and polarity into ev_key/ev_press, clear the slot, ev_valid←1, go to OFFER.
  - OFFER: hold ev_valid, ev_key and ev_press stable until ev_ready. On handshake, ev_valid←0 and go to IDLE.
  - No back-to-back grant: at most one event per 2 cycles.
- Reset values: key_level=0, counters=0, slots empty, ev_valid=0, ev_key=0, ev_press=0, overrun=0, rr_ptr=0, state IDLE.
- Reset mid-operation discards all pending and offered events.
- A key held through reset release yields a press event once it is filtered.

## Timing
- key_in step to key_level change: 2 (sync) + SAMPLE_TIME cycles.
- key_level change to ev_valid high, with the port idle: 2 cycles (slot load, then grant).
- Glitch shorter than SAMPLE_TIME cycles after sync: no level change, no event.
- ev_ready is sampled only in OFFER. ev_ready high in IDLE has no effect.
- With ev_ready held high, the sustained rate is one event per 2 cycles.

## Configuration
- KEY_RELEASE_EV_EN defined: release edges load slots and generate events with ev_press=0.
- KEY_RELEASE_EV_EN undefined: release edges only update key_level. They never load a slot or set overrun. ev_press is tied to 1.

## Structure
- Shared package key_pkg holds:
  - the state enum (KEY_IDLE, KEY_OFFER);
  - the pending-slot struct {valid, polarity};
  - a function returning the next round-robin grant index.
- Sub-module key_filter holds one key's synchroniser, stability counter and key_level register. It is instantiated NKEYS times via generate. Scheduling stays in key_event_ctrl.

## Test plan
- Test configuration for all scenarios: SAMPLE_TIME=4, NKEYS=4, KEY_RELEASE_EV_EN defined.
- Reset values: assert reset 3 cycles with key_in=4'b1111 → all outputs 0. After release, four press events arrive in index order 0,1,2,3.
- Single press: key_in[2] 0→1 at cycle T, ev_ready=1 → key_level[2] rises at T+6. ev_valid=1 at T+8 with ev_key=2, ev_press=1 for exactly 1 cycle.
- Glitch reject: key_in[1] high for 3 cycles → key_level stays 0, no event, overrun=0.
- Round-robin: keys 0 and 3 press in the same cycle, ev_ready=1 → events key0 then key3. A later simultaneous press on keys 0 and 3 yields key0 first again, since rr_ptr=0 after wrap from key3.
- Backpressure/overrun: ev_ready=0, key0 pressed, released, then pressed again, all filtered.
  - ev_key=0 press is held stable in OFFER.
  - The release occupies the slot and the second press sets overrun=1.
  - Raising ev_ready yields press then release; overrun stays 1.
- Macro off: rebuild without KEY_RELEASE_EV_EN and apply a press/release of key1 → exactly one event (ev_key=1, ev_press=1). key_level[1] returns to 0.
